// File: rtl/sa_4x4_ws_if.sv
// Bus bundle for the 4x4 weight-stationary systolic array: skewed stream in,
// serial weight loader, aligned column results out.
interface sa_4x4_ws_if #(
   parameter int ACC_W = 36
);
   logic                    srt_sig;
   logic signed [15:0]      in1, in2, in3, in4;
   logic                    w_load;
   logic signed [15:0]      w_in;
   logic                    w_commit;
   logic                    w_full;
   logic                    out_valid;
   logic signed [ACC_W-1:0] out1, out2, out3, out4;

   modport master (
      output srt_sig, in1, in2, in3, in4, w_load, w_in, w_commit,
      input  w_full, out_valid, out1, out2, out3, out4
   );

   modport slave (
      input  srt_sig, in1, in2, in3, in4, w_load, w_in, w_commit,
      output w_full, out_valid, out1, out2, out3, out4
   );
endinterface

// File: rtl/sa_4x4_ws.sv
// 4x4 weight-stationary systolic MAC array with shadow/active weight banks and output deskew.
// Optional SA_RELU_EN: clamp negative column results to zero at the output.

module sa_pe #(
   parameter int ACC_W = 36
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [15:0]      w,
   input  logic signed [15:0]      xi,
   input  logic signed [ACC_W-1:0] ps_in,
   output logic signed [15:0]      xr,
   output logic signed [ACC_W-1:0] ps
);
   logic signed [31:0] prod;

   assign prod = w * xi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xr <= '0;
         ps <= '0;
      end else begin
         xr <= xi;
         ps <= ps_in + {{(ACC_W-32){prod[31]}}, prod};
      end
   end
endmodule

module sa_4x4_ws #(
   parameter  int ACC_W  = 36,
   localparam int N      = 4,
   localparam int STAGES = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   sa_4x4_ws_if.slave   bus
);
   typedef enum logic [1:0] {W_EMPTY, W_LOADING, W_FULL} wst_t;

   typedef struct packed {
      logic        load;
      logic        commit;
      logic [15:0] data;
   } wreq_t;

   wreq_t                              wreq;
   wst_t                               wst;
   logic [3:0]                         w_cnt;
   logic                               w_full_r;
   logic [N*N-1:0][15:0]               sh;
   logic [N-1:0][N-1:0][15:0]          wa;
   logic [N-1:0][15:0]                 x;
   logic [N-1:0][N-2:0][15:0]          xh;
   logic [N-1:0][15:0]                 xr_unused;
   logic [N-1:0][N-1:0][ACC_W-1:0]     ps;
   logic [N-1:0][ACC_W-1:0]            tail;
   logic [N-1:0][ACC_W-1:0]            res;
   logic [STAGES:0]                    vld_pipe;

   assign wreq = '{load: bus.w_load, commit: bus.w_commit, data: bus.w_in};
   assign x    = {bus.in4, bus.in3, bus.in2, bus.in1};

   // Weight loader; a same-edge load is forwarded into the committed bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh       <= '0;
         wa       <= '0;
         w_cnt    <= '0;
         wst      <= W_EMPTY;
         w_full_r <= 1'b0;
      end else begin
         if (wreq.load) sh[w_cnt] <= wreq.data;
         if (wreq.commit) begin
            for (int r = 0; r < N; r++)
               for (int c = 0; c < N; c++)
                  wa[r][c] <= (wreq.load && w_cnt == 4'(r*N + c)) ? wreq.data : sh[r*N + c];
            w_cnt    <= '0;
            wst      <= W_EMPTY;
            w_full_r <= 1'b0;
         end else if (wreq.load) begin
            w_cnt <= w_cnt + 4'd1;
            case (wst)
               W_EMPTY:   wst <= W_LOADING;
               W_LOADING: if (w_cnt == 4'(N*N-1)) begin
                     wst      <= W_FULL;
                     w_full_r <= 1'b1;
                  end
               W_FULL: begin
                  wst      <= W_LOADING;
                  w_full_r <= 1'b0;
               end
               default:   wst <= W_EMPTY;
            endcase
         end
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic [15:0]      xi_w;
         logic [15:0]      xo;
         logic [ACC_W-1:0] ps_a;

         if (j == 0) begin : g_xin
            assign xi_w = x[k];
         end else begin : g_xpass
            assign xi_w = xh[k][j-1];
         end

         if (k == 0) begin : g_ptop
            assign ps_a = '0;
         end else begin : g_pdown
            assign ps_a = ps[k-1][j];
         end

         if (j == N-1) begin : g_xend
            assign xr_unused[k] = xo;
         end else begin : g_xfwd
            assign xh[k][j] = xo;
         end

         sa_pe #(.ACC_W(ACC_W)) u_pe (
            .clk   (clk),
            .rst_n (rst_n),
            .w     (wa[k][j]),
            .xi    (xi_w),
            .ps_in (ps_a),
            .xr    (xo),
            .ps    (ps[k][j])
         );
      end
   end

   // Column j leaves the array j cycles after column 0; pad with N-1-j registers.
   for (genvar j = 0; j < N; j++) begin : g_dsk
      localparam int D = N - 1 - j;
      if (D == 0) begin : g_pass
         assign tail[j] = ps[N-1][j];
      end else begin : g_reg
         logic [D-1:0][ACC_W-1:0] sr;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sr <= '0;
            else begin
               sr[0] <= ps[N-1][j];
               for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
            end
         end
         assign tail[j] = sr[D-1];
      end
`ifdef SA_RELU_EN
      assign res[j] = tail[j][ACC_W-1] ? '0 : tail[j];
`else
      assign res[j] = tail[j];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_pipe <= '0;
      else        vld_pipe <= {vld_pipe[STAGES-1:0], bus.srt_sig};
   end

   assign bus.out_valid = vld_pipe[STAGES];
   assign bus.w_full    = w_full_r;
   assign bus.out1      = res[0];
   assign bus.out2      = res[1];
   assign bus.out3      = res[2];
   assign bus.out4      = res[3];
endmodule

// File: tb/tb_sa_4x4_ws.sv
// Directed bench for sa_4x4_ws: weight load/commit, skewed streams, overflow, reset mid-stream.
module tb_sa_4x4_ws;
   logic clk;
   logic rst_n;
   int   n_chk, n_pass;

   logic signed [15:0] xv [16][4];
   longint             ev [16][4];
   int                 nv;

   sa_4x4_ws_if #(.ACC_W(36)) bus ();

   sa_4x4_ws #(.ACC_W(36)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic signed [15:0] v, input bit cmt);
      bus.w_load   = 1'b1;
      bus.w_in     = v;
      bus.w_commit = cmt;
      tick();
      bus.w_load   = 1'b0;
      bus.w_commit = 1'b0;
   endtask

   task automatic commit();
      bus.w_commit = 1'b1;
      tick();
      bus.w_commit = 1'b0;
   endtask

   task automatic drive_row(input int c);
      logic signed [15:0] v [4];
      for (int k = 0; k < 4; k++) begin
         int idx;
         idx  = c - k;
         v[k] = (idx >= 0 && idx < nv) ? xv[idx][k] : 16'sd0;
      end
      bus.in1     = v[0];
      bus.in2     = v[1];
      bus.in3     = v[2];
      bus.in4     = v[3];
      bus.srt_sig = (c < nv);
   endtask

   task automatic run_stream(input string tag);
      for (int c = 0; c <= nv + 6; c++) begin
         int v;
         drive_row(c);
         tick();
         v = c - 6;
         if (v >= 0 && v < nv) begin
            chk({tag, "_vld"}, longint'(bus.out_valid), 1);
            chk({tag, "_o1"},  bus.out1, ev[v][0]);
            chk({tag, "_o2"},  bus.out2, ev[v][1]);
            chk({tag, "_o3"},  bus.out3, ev[v][2]);
            chk({tag, "_o4"},  bus.out4, ev[v][3]);
         end else begin
            chk({tag, "_idle"}, longint'(bus.out_valid), 0);
         end
      end
      nv = 0;
      drive_row(0);
   endtask

   initial begin
      n_chk = 0; n_pass = 0; nv = 0;
      rst_n = 1'b0;
      bus.srt_sig = 1'b0; bus.w_load = 1'b0; bus.w_commit = 1'b0; bus.w_in = '0;
      bus.in1 = '0; bus.in2 = '0; bus.in3 = '0; bus.in4 = '0;
      repeat (3) tick();
      rst_n = 1'b1;

      // idle after reset
      repeat (20) tick();
      chk("rst_vld",  longint'(bus.out_valid), 0);
      chk("rst_o1",   bus.out1, 0);
      chk("rst_o4",   bus.out4, 0);
      chk("rst_full", longint'(bus.w_full), 0);

      // identity weights, one vector
      for (int i = 0; i < 16; i++) wr((i % 5 == 0) ? 16'sd1 : 16'sd0, 1'b0);
      chk("id_full", longint'(bus.w_full), 1);
      commit();
      chk("id_full_clr", longint'(bus.w_full), 0);
      nv = 1;
      xv[0] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
      ev[0] = '{1, 2, 3, 4};
      run_stream("ident");

      // all-ones weights, 9 back-to-back vectors
      for (int i = 0; i < 16; i++) wr(16'sd1, 1'b0);
      commit();
      nv = 9;
      for (int c = 1; c <= 9; c++)
         for (int k = 0; k < 4; k++) begin
            xv[c-1][k] = 16'(c);
            ev[c-1][k] = 4 * c;
         end
      run_stream("ones");

      // extreme negative operands: 4 * 2^30 = 2^32
      for (int i = 0; i < 16; i++) wr(-16'sd32768, 1'b0);
      commit();
      nv = 1;
      xv[0] = '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768};
      ev[0] = '{64'sd4294967296, 64'sd4294967296, 64'sd4294967296, 64'sd4294967296};
      run_stream("ovf");

      // negative column sum: -1 * 5 * 4
      for (int i = 0; i < 16; i++) wr(-16'sd1, 1'b0);
      commit();
      nv = 1;
      xv[0] = '{16'sd5, 16'sd5, 16'sd5, 16'sd5};
`ifdef SA_RELU_EN
      ev[0] = '{0, 0, 0, 0};
`else
      ev[0] = '{-20, -20, -20, -20};
`endif
      run_stream("neg");

      // 17 loads wrap onto shadow[0]
      for (int i = 0; i < 16; i++) wr(16'sd0, 1'b0);
      chk("wrap_full16", longint'(bus.w_full), 1);
      wr(16'sd7, 1'b0);
      chk("wrap_full17", longint'(bus.w_full), 0);
      commit();
      nv = 1;
      xv[0] = '{-16'sd3, 16'sd1, 16'sd1, 16'sd1};
`ifdef SA_RELU_EN
      ev[0] = '{0, 0, 0, 0};
`else
      ev[0] = '{-21, 0, 0, 0};
`endif
      run_stream("wrap");

      // load and commit on the same edge
      wr(-16'sd2, 1'b1);
      chk("same_full", longint'(bus.w_full), 0);
      nv = 1;
      xv[0] = '{-16'sd3, 16'sd1, 16'sd1, 16'sd1};
      ev[0] = '{6, 0, 0, 0};
      run_stream("same");

      // fill shadow without commit, then reset mid-stream
      for (int i = 0; i < 16; i++) wr(16'sd5, 1'b0);
      chk("pre_full", longint'(bus.w_full), 1);
      nv = 4;
      for (int v = 0; v < 4; v++) xv[v] = '{-16'sd3, 16'sd0, 16'sd0, 16'sd0};
      for (int c = 0; c <= 6; c++) begin
         drive_row(c);
         tick();
      end
      chk("mid_vld", longint'(bus.out_valid), 1);
      chk("mid_o1",  bus.out1, 6);
      rst_n = 1'b0;
      nv = 0;
      drive_row(0);
      #1;
      chk("arst_vld",  longint'(bus.out_valid), 0);
      chk("arst_o1",   bus.out1, 0);
      chk("arst_full", longint'(bus.w_full), 0);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 7; c++) begin
         tick();
         chk("post_vld", longint'(bus.out_valid), 0);
      end
      chk("post_o1", bus.out1, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
